// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: control-unit commands, instruction-memory handshake and decoded outputs.
// The fetch unit is the slave; the control unit / memory side (or a bench) is the master.
interface instr_fetch_unit_if;
  logic        fetch_req;
  logic        pc_inc;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] program_counter;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] imm;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_error;

  modport slave (
    input  fetch_req, pc_inc, pc_load, pc_load_value, imem_ready, imem_rdata,
    output imem_req, imem_addr, program_counter, instruction, opcode,
           rd_idx, rs1_idx, rs2_idx, imm, instr_valid, fetch_busy, fetch_error
  );

  modport master (
    output fetch_req, pc_inc, pc_load, pc_load_value, imem_ready, imem_rdata,
    input  imem_req, imem_addr, program_counter, instruction, opcode,
           rd_idx, rs1_idx, rs2_idx, imm, instr_valid, fetch_busy, fetch_error
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle RV32I fetch/decode front stage: PC register, one-word fetch over a ready
// handshake with timeout/misalignment abort, and combinational field decode of the held word.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0013
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_unit_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      addr_q;
  logic [31:0]      instr_q;
  logic             req_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [31:0] imm_decode(input logic [31:0] w);
    logic [31:0] r;
    case (w[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        r = {{20{w[31]}}, w[31:20]};
      7'b0100011:
        r = {{20{w[31]}}, w[31:25], w[11:7]};
      7'b1100011:
        r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        r = {w[31:12], 12'h000};
      7'b1101111:
        r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:
        r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Next PC: commands only take effect while idle, load wins over increment
  always_comb begin
    pc_d = pc_q;
    if (state_q == IDLE) begin
      if (bus.pc_load) begin
        pc_d = bus.pc_load_value;
      end else if (bus.pc_inc) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Fetch FSM with registered handshake, status and captured instruction word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= 32'h0000_0000;
      instr_q <= NOP_WORD;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.fetch_req) begin
            if (pc_q[1:0] != 2'b00) begin
              instr_q <= NOP_WORD;
              err_q   <= 1'b1;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= pc_q;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          // A response arriving on the last allowed cycle still counts as success
          if (bus.imem_ready) begin
            instr_q <= bus.imem_rdata;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            instr_q <= NOP_WORD;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req        = req_q;
  assign bus.imem_addr       = addr_q;
  assign bus.fetch_busy      = req_q;
  assign bus.program_counter = pc_q;
  assign bus.instruction     = instr_q;
  assign bus.instr_valid     = valid_q;
  assign bus.fetch_error     = err_q;
  assign bus.opcode          = instr_q[6:0];
  assign bus.rd_idx          = instr_q[11:7];
  assign bus.rs1_idx         = instr_q[19:15];
  assign bus.rs2_idx         = instr_q[24:20];
  assign bus.imm             = imm_decode(instr_q);

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multicycle RV32I fetch/decode front stage. Holds the program counter, fetches one 32-bit instruction word per request over a ready-based instruction-memory handshake, and registers the decoded fields (opcode, register indices, sign-extended immediate) consumed by the control unit. The control unit drives it with a fetch request in its fetch stage and PC update commands in its PC-increase stage.

## Interface

- RESET_PC, 32'h0000_0000, PC value after reset (must be word aligned)
- TIMEOUT_CYCLES, 16, max cycles to wait for imem_ready before abort (>=1)
- NOP_WORD, 32'h0000_0013, instruction substituted on error (ADDI x0,x0,0)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- fetch_req  in  1  one-cycle pulse: start a fetch at current PC
- pc_inc  in  1  PC <= PC + 4
- pc_load  in  1  PC <= pc_load_value (priority over pc_inc)
- pc_load_value  in  32  new PC for pc_load
- imem_req  out  1  memory request, held until ready
- imem_addr  out  32  fetch address (= PC at request), stable while imem_req
- imem_ready  in  1  memory response; imem_rdata valid same cycle
- imem_rdata  in  32  instruction word
- program_counter  out  32  current PC
- instruction  out  32  last fetched word (or NOP_WORD)
- opcode  out  7  instruction[6:0]
- rd_idx, rs1_idx, rs2_idx  out  5 each  instruction[11:7], [19:15], [24:20]
- imm  out  32  sign-extended immediate per format
- instr_valid  out  1  one-cycle pulse: decoded outputs updated
- fetch_busy  out  1  high in REQ/WAIT
- fetch_error  out  1  sticky-per-fetch: last fetch aborted (misaligned or timeout)

## Operation

- FSM: IDLE, REQ, DONE.
  - IDLE: on fetch_req, if PC[1:0]!=0 -> DONE with error; else -> REQ, latch imem_addr=PC, clear timeout counter.
  - REQ: imem_req=1. imem_ready=1 -> capture imem_rdata, -> DONE. Counter reaches TIMEOUT_CYCLES with no ready -> capture NOP_WORD, error, -> DONE.
  - DONE: instr_valid=1 for this cycle; -> IDLE.
- fetch_error updated at each fetch completion (1 on abort, 0 on success).
- PC commands honoured only in IDLE; ignored in REQ/DONE. pc_load beats pc_inc when both high. PC wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- fetch_req outside IDLE ignored (no queueing).
- Immediate decode from registered instruction, by opcode:
  - I (0010011, 0000011, 1100111, 1110011): sext(instr[31:20])
  - S (0100011): sext({instr[31:25], instr[11:7]})
  - B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U (0110111, 0010111): {instr[31:12], 12'b0}
  - J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - R/other: 0
- Decoded outputs are purely combinational from the instruction register; they change only when instruction changes.

## Timing

- Reset values: PC=RESET_PC, instruction=NOP_WORD (so opcode=0010011, imm=0, indices 0), state IDLE, imem_req=0, imem_addr=0, instr_valid=0, fetch_busy=0, fetch_error=0.
- Reset mid-fetch: imem_req deasserts asynchronously on rst low; any pending response is discarded.
- fetch_req at edge N -> imem_req high from cycle N+1. imem_ready sampled at edge M -> instr_valid high in cycle M+1, new decoded outputs visible in M+1. Minimum fetch_req-to-instr_valid: 2 cycles.
- Timeout: imem_req high for exactly TIMEOUT_CYCLES cycles, then drops; instr_valid next cycle.
- Misaligned: no imem_req; instr_valid one cycle after fetch_req.
- imem_ready while imem_req=0 ignored.
- PC update visible the cycle after the command edge.

## Test plan

- Reset, fetch at PC=0, memory returns 0x00500093 after 3 wait cycles -> imem_req high 4 cycles, instr_valid once, opcode=0x13, rd=1, rs1=0, imm=5, fetch_error=0.
- Decode sweep: words 0xFE000EE3 (B, imm=-4), 0x12345037 (U, imm=0x12345000), 0x0080006F (J, imm=8), 0xFE112E23 (S, imm=-4), 0x002081B3 (R, imm=0) -> listed imm values.
- pc_load 0x100 and pc_inc same cycle -> PC=0x100; pc_inc at PC=0xFFFF_FFFC -> PC=0; pc_inc during REQ -> PC unchanged.
- No imem_ready -> imem_req held exactly 16 cycles, instruction=0x00000013, fetch_error=1, instr_valid once; next successful fetch clears fetch_error.
- pc_load 0x102 then fetch_req -> no imem_req, fetch_error=1, instr_valid one cycle after request.
- rst low during WAIT -> imem_req drops immediately, PC=RESET_PC, no instr_valid; late imem_ready ignored.
